// File: rtl/uart_rx.sv
// uart_rx: 8N1 UART receiver, BAUD_DIV clocks per bit, samples each bit near its middle.
// Define UART_RX_FRAME_ERR_EN to add the frame_err pulse output.
module uart_rx #(
   parameter int BAUD_DIV = 4
) (
   input  logic       clk,
   input  logic       reset_n,
   input  logic       rx,
   output logic [7:0] data_out,
   output logic       rx_done
`ifdef UART_RX_FRAME_ERR_EN
   ,
   output logic       frame_err
`endif
);

   localparam int CNT_W = $clog2(BAUD_DIV) + 1;
   localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(BAUD_DIV / 2 - 1);
   localparam logic [CNT_W-1:0] FULL_LAST = CNT_W'(BAUD_DIV - 1);

   typedef enum logic [2:0] {
      IDLE,
      START,
      DATA,
      STOP,
      WAIT_IDLE
   } state_t;

   state_t           state;
   logic [CNT_W-1:0] baud_cnt;
   logic [2:0]       bit_idx;
   logic [7:0]       shift_reg;
   logic             rx_sync_p0;
   logic             rx_s;

   // Stage p0 -> rx_s: two-flop synchronizer, idles high
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         rx_sync_p0 <= 1'b1;
         rx_s       <= 1'b1;
      end else begin
         rx_sync_p0 <= rx;
         rx_s       <= rx_sync_p0;
      end
   end

   // Frame FSM: all outputs registered, pulses default low every cycle
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state     <= IDLE;
         baud_cnt  <= '0;
         bit_idx   <= '0;
         shift_reg <= '0;
         data_out  <= '0;
         rx_done   <= 1'b0;
`ifdef UART_RX_FRAME_ERR_EN
         frame_err <= 1'b0;
`endif
      end else begin
         rx_done <= 1'b0;
`ifdef UART_RX_FRAME_ERR_EN
         frame_err <= 1'b0;
`endif
         case (state)
            IDLE: begin
               bit_idx  <= '0;
               baud_cnt <= '0;
               if (!rx_s) state <= START;
            end
            START: begin
               if (baud_cnt == HALF_LAST) begin
                  baud_cnt <= '0;
                  bit_idx  <= '0;
                  if (!rx_s) begin
                     state <= DATA;
                  end else begin
                     state <= IDLE;
`ifdef UART_RX_FRAME_ERR_EN
                     frame_err <= 1'b1;
`endif
                  end
               end else begin
                  baud_cnt <= baud_cnt + 1'b1;
               end
            end
            DATA: begin
               if (baud_cnt == FULL_LAST) begin
                  baud_cnt  <= '0;
                  shift_reg <= {rx_s, shift_reg[7:1]};
                  bit_idx   <= bit_idx + 1'b1;
                  if (bit_idx == 3'd7) state <= STOP;
               end else begin
                  baud_cnt <= baud_cnt + 1'b1;
               end
            end
            STOP: begin
               if (baud_cnt == FULL_LAST) begin
                  baud_cnt <= '0;
                  if (rx_s) begin
                     data_out <= shift_reg;
                     rx_done  <= 1'b1;
                     state    <= IDLE;
                  end else begin
                     state <= WAIT_IDLE;
`ifdef UART_RX_FRAME_ERR_EN
                     frame_err <= 1'b1;
`endif
                  end
               end else begin
                  baud_cnt <= baud_cnt + 1'b1;
               end
            end
            WAIT_IDLE: begin
               // A break (line held low) must not be mistaken for a new start bit
               if (rx_s) state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_uart_rx.sv
// Bench for uart_rx: directed vector table, hand-written corner sequences and random frames
// scored against a queue of expected bytes.
`timescale 1ns/1ps
module tb_uart_rx;

   localparam int BAUD_DIV = 4;

   logic       clk = 1'b0;
   logic       reset_n = 1'b0;
   logic       rx = 1'b1;
   logic [7:0] data_out;
   logic       rx_done;
`ifdef UART_RX_FRAME_ERR_EN
   logic       frame_err;
`endif

   int total = 0;
   int bad = 0;
   int done_cnt = 0;
   int ferr_cnt = 0;
   int exp_done = 0;
   int exp_ferr = 0;
   logic [7:0] exp_q[$];
   logic [7:0] last_good = 8'h00;
   logic       prev_done = 1'b0;

   uart_rx #(.BAUD_DIV(BAUD_DIV)) dut (
      .clk      (clk),
      .reset_n  (reset_n),
      .rx       (rx),
      .data_out (data_out),
      .rx_done  (rx_done)
`ifdef UART_RX_FRAME_ERR_EN
      ,
      .frame_err(frame_err)
`endif
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h, want %0h", name, act, exp);
      end
   endtask

   // Scoreboard: every rx_done must match the oldest outstanding good frame
   always @(negedge clk) begin
      if (rx_done) begin
         done_cnt++;
         check("done_not_back_to_back", {31'd0, prev_done}, 32'd0);
         check("done_expected", {31'd0, exp_q.size() != 0}, 32'd1);
         if (exp_q.size() != 0) check("done_data", {24'd0, data_out}, {24'd0, exp_q.pop_front()});
      end
      prev_done = rx_done;
`ifdef UART_RX_FRAME_ERR_EN
      if (frame_err) ferr_cnt++;
`endif
   end

   // Called and returns #1 after a rising edge; holds rx for n cycles
   task automatic hold(input logic v, input int n);
      rx = v;
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic send_frame(input logic [7:0] b, input logic stop_ok);
      if (stop_ok) begin
         exp_q.push_back(b);
         exp_done++;
         last_good = b;
      end else begin
         exp_ferr++;
      end
      hold(1'b0, BAUD_DIV);
      for (int i = 0; i < 8; i++) hold(b[i], BAUD_DIV);
      hold(stop_ok, BAUD_DIV);
   endtask

   task automatic checkpoint(input string tag, input logic [7:0] exp_out);
      check({tag, "_data_out"}, {24'd0, data_out}, {24'd0, exp_out});
      check({tag, "_done_count"}, done_cnt, exp_done);
`ifdef UART_RX_FRAME_ERR_EN
      check({tag, "_frame_err_count"}, ferr_cnt, exp_ferr);
`endif
   endtask

   typedef struct {
      logic [7:0] data;
      logic       stop_ok;
      int         gap;
      logic [7:0] exp_out;
   } vec_t;

   vec_t vecs[6];

   initial begin : watchdog
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "timeout");
   end

   initial begin : main
      logic [7:0] rb;
      logic       rok;
      int         rgap;

      vecs[0] = '{8'h2B, 1'b1, 8, 8'h2B};
      vecs[1] = '{8'h55, 1'b1, 8, 8'h55};
      vecs[2] = '{8'h00, 1'b1, 0, 8'h55};
      vecs[3] = '{8'hFF, 1'b1, 6, 8'hFF};
      vecs[4] = '{8'h3C, 1'b0, 6, 8'hFF};
      vecs[5] = '{8'h3C, 1'b1, 6, 8'h3C};

      // Reset state
      reset_n = 1'b0;
      rx = 1'b1;
      repeat (5) @(posedge clk);
      #1;
      check("reset_data_out", {24'd0, data_out}, 32'h00);
      check("reset_rx_done", {31'd0, rx_done}, 32'd0);
      reset_n = 1'b1;
      hold(1'b1, 10);
      checkpoint("after_reset", 8'h00);

      // Directed vector table
      for (int v = 0; v < 6; v++) begin
         send_frame(vecs[v].data, vecs[v].stop_ok);
         if (!vecs[v].stop_ok) hold(1'b0, 20);
         hold(1'b1, vecs[v].gap);
         if (vecs[v].gap >= 3) checkpoint($sformatf("vec%0d", v), vecs[v].exp_out);
      end

      // One-cycle glitch on an idle line
      hold(1'b0, 1);
      exp_ferr++;
      hold(1'b1, 12);
      checkpoint("glitch", 8'h3C);
      send_frame(8'hA5, 1'b1);
      hold(1'b1, 6);
      checkpoint("after_glitch", 8'hA5);

      // Reset in the middle of a data bit
      hold(1'b0, BAUD_DIV);
      hold(1'b1, BAUD_DIV);
      hold(1'b0, BAUD_DIV);
      hold(1'b0, BAUD_DIV);
      hold(1'b0, 2);
      reset_n = 1'b0;
      rx = 1'b1;
      #1;
      check("midreset_data_out", {24'd0, data_out}, 32'h00);
      check("midreset_rx_done", {31'd0, rx_done}, 32'd0);
      last_good = 8'h00;
      repeat (3) @(posedge clk);
      #1;
      reset_n = 1'b1;
      hold(1'b1, 50);
      checkpoint("after_midreset", 8'h00);
      send_frame(8'h81, 1'b1);
      hold(1'b1, 6);
      checkpoint("frame_81", 8'h81);

      // Random frames, some with broken stop bits, random idle gaps
      for (int i = 0; i < 40; i++) begin
         rb = 8'($urandom);
         rok = ($urandom_range(0, 7) != 0);
         rgap = int'($urandom_range(0, 6));
         send_frame(rb, rok);
         if (!rok) begin
            hold(1'b0, int'($urandom_range(0, 12)));
            rgap = rgap + 2;
         end
         hold(1'b1, rgap);
      end
      hold(1'b1, 20);
      check("random_queue_drained", exp_q.size(), 32'd0);
      checkpoint("random_end", last_good);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
